fde_controller: RTL and testbench
=================================

FDE_CONTROLLER -- requirements
Module: fde_controller

Interface
REQ-001 Parameter PC_W, default 4: program-counter width; pc wraps modulo 2^PC_W.
REQ-002 Parameter HALT_OP, default 4'hE: opcode value that halts the sequencer.
REQ-003 The module SHALL have one clock and a synchronous, active-low reset.
REQ-004 clk  input  1  system clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous active-low reset.
REQ-006 stop  input  1  1 = do not start a new instruction; the current instruction always completes.
REQ-007 instr_in  input  16  instruction word from instruction memory, combinationally valid for pc during FETCH.
REQ-008 pc  output  PC_W  current program counter, also the instruction-memory address.
REQ-009 opcode  output  4  IR[15:12].
REQ-010 dstadd  output  4  IR[11:8].
REQ-011 srcadd_1  output  4  IR[7:4].
REQ-012 srcadd_2  output  4  IR[3:0].
REQ-013 state  output  3  IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, WRITEBACK=4, HALT=5.
REQ-014 ir_load  output  1  high only in FETCH.
REQ-015 alu_en  output  1  high only in EXECUTE.
REQ-016 rf_we  output  1  register-file write strobe; conditions are given in REQ-021.
REQ-017 halted  output  1  high only in HALT.

Function
REQ-018 IDLE: stop=1 holds IDLE; stop=0 moves to FETCH on the next edge.
REQ-019 FETCH: ir_load=1; IR captures instr_in at the end of the cycle; next state is DECODE.
REQ-020 DECODE and EXECUTE: opcode/dstadd/srcadd_1/srcadd_2 are driven from IR (registered, stable through WRITEBACK); DECODE moves to EXECUTE; in EXECUTE, opcode==HALT_OP moves to HALT, otherwise to WRITEBACK.
REQ-021 WRITEBACK: rf_we=1 unless opcode is 4'h0 (NOP) or the jump opcode defined in REQ-031; pc updates at the end of the cycle; next state is IDLE if stop=1, else FETCH.
REQ-022 Latency: exactly 4 cycles per instruction (FETCH..WRITEBACK) with stop=0; there is no IDLE cycle between back-to-back instructions.
REQ-023 pc increments by 1 only at the end of WRITEBACK (unless REQ-031 applies); 2^PC_W-1 wraps to 0.
REQ-024 stop is sampled only in IDLE and at the end of WRITEBACK; a stop asserted mid-instruction has no effect until WRITEBACK.
REQ-025 HALT: the state is terminal; pc is frozen at the HALT instruction address; stop is ignored; only reset exits.
REQ-026 At most one of ir_load, alu_en, rf_we, halted is high in any cycle.
REQ-027 Undefined state encodings 6 and 7 return to IDLE on the next edge.

Reset
REQ-028 Reset is applied when reset=0 at a rising edge, and it overrides every state, including HALT and a mid-instruction state.
REQ-029 Reset values: state=IDLE, pc=0, IR=16'h0000 (so opcode/dstadd/srcadd_1/srcadd_2 are all 0), and ir_load=alu_en=rf_we=halted=0.
REQ-030 After reset is released, the first FETCH occurs no earlier than the first edge at which stop=0 is seen in IDLE.

Configuration
REQ-031 With macro FDE_BRANCH_EN defined, opcode 4'hF is JMP: rf_we=0 in WRITEBACK and pc loads IR[PC_W-1:0] instead of incrementing.
REQ-032 Without FDE_BRANCH_EN, opcode 4'hF is an ordinary ALU opcode: rf_we=1 in WRITEBACK and pc increments.

Verification
REQ-033 Reset/stop: hold reset=0 for 2 cycles, then reset=1 with stop=1 for 5 cycles -> state=IDLE, pc=0, all strobes 0 throughout.
REQ-034 Run: memory[0]=16'h1123, memory[1]=16'h2456, stop=0 -> state sequence 1,2,3,4,1,2,3,4; rf_we pulses with dstadd=1, then with dstadd=4; pc=2 after the 8th cycle.
REQ-035 Mid-instruction stop: assert stop in EXECUTE of the instruction at pc=0 -> that instruction's WRITEBACK completes, pc becomes 1, then IDLE; releasing stop -> FETCH at pc=1.
REQ-036 Halt: memory[2]=16'hE000 -> HALT reached 3 cycles after its FETCH, halted=1, pc=2, rf_we never asserted for it; toggling stop has no effect; reset=0 -> IDLE, pc=0.
REQ-037 Wrap: PC_W=4, all 16 words are NOP (16'h0000) -> pc goes 15 to 0 after the 16th WRITEBACK; rf_we stays 0 throughout.
REQ-038 Branch: memory[3]=16'hF009 -> with FDE_BRANCH_EN, next FETCH at pc=9 with rf_we=0; without FDE_BRANCH_EN, rf_we=1, dstadd=0, next pc=4.

Source files
------------

// File: rtl/fde_if.sv
// Instruction-memory and decode bundle between the fetch/decode/execute controller and its datapath.
interface fde_if #(
  parameter int PC_W = 4
);
  logic            stop;
  logic [15:0]     instr_in;
  logic [PC_W-1:0] pc;
  logic [3:0]      opcode;
  logic [3:0]      dstadd;
  logic [3:0]      srcadd_1;
  logic [3:0]      srcadd_2;
  logic [2:0]      state;
  logic            ir_load;
  logic            alu_en;
  logic            rf_we;
  logic            halted;

  modport master (
    input  stop, instr_in,
    output pc, opcode, dstadd, srcadd_1, srcadd_2, state,
           ir_load, alu_en, rf_we, halted
  );

  modport slave (
    output stop, instr_in,
    input  pc, opcode, dstadd, srcadd_1, srcadd_2, state,
           ir_load, alu_en, rf_we, halted
  );
endinterface

// File: rtl/fde_controller.sv
// Four-cycle fetch/decode/execute/writeback sequencer with a terminal HALT state.
// Optional feature: define FDE_BRANCH_EN to make opcode 4'hF a jump to IR[PC_W-1:0].
module fde_controller #(
  parameter int          PC_W    = 4,
  parameter logic [3:0]  HALT_OP = 4'hE
) (
  input  logic clk,
  input  logic reset,
  fde_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_nextPc;
  logic [15:0]     r_ir;
  logic            w_isJump;
  logic            w_irLoad;
  logic            w_aluEn;
  logic            w_rfWe;
  logic            w_halted;

`ifdef FDE_BRANCH_EN
  assign w_isJump = (r_ir[15:12] == 4'hF);
`else
  assign w_isJump = 1'b0;
`endif

  assign w_nextPc = w_isJump ? r_ir[PC_W-1:0] : r_pc + 1'b1;

  // IR is only written in FETCH and pc only advances at the end of WRITEBACK.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_ir    <= 16'h0000;
    end else begin
      r_state <= w_nextState;
      if (r_state == S_FETCH) begin
        r_ir <= bus.instr_in;
      end
      if (r_state == S_WRITEBACK) begin
        r_pc <= w_nextPc;
      end
    end
  end

  always_comb begin
    w_nextState = S_IDLE;
    w_irLoad    = 1'b0;
    w_aluEn     = 1'b0;
    w_rfWe      = 1'b0;
    w_halted    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_nextState = bus.stop ? S_IDLE : S_FETCH;
      end
      S_FETCH: begin
        w_irLoad    = 1'b1;
        w_nextState = S_DECODE;
      end
      S_DECODE: begin
        w_nextState = S_EXECUTE;
      end
      S_EXECUTE: begin
        w_aluEn     = 1'b1;
        w_nextState = (r_ir[15:12] == HALT_OP) ? S_HALT : S_WRITEBACK;
      end
      S_WRITEBACK: begin
        w_rfWe      = (r_ir[15:12] != 4'h0) && !w_isJump;
        w_nextState = bus.stop ? S_IDLE : S_FETCH;
      end
      S_HALT: begin
        w_halted    = 1'b1;
        w_nextState = S_HALT;
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  assign bus.pc       = r_pc;
  assign bus.opcode   = r_ir[15:12];
  assign bus.dstadd   = r_ir[11:8];
  assign bus.srcadd_1 = r_ir[7:4];
  assign bus.srcadd_2 = r_ir[3:0];
  assign bus.state    = r_state;
  assign bus.ir_load  = w_irLoad;
  assign bus.alu_en   = w_aluEn;
  assign bus.rf_we    = w_rfWe;
  assign bus.halted   = w_halted;

endmodule

// File: tb/tb_fde_controller.sv
// Scoreboard bench for fde_controller: an instruction-level program model queues expected commits.
module tb_fde_controller;

  localparam int PCW = 4;
`ifdef FDE_BRANCH_EN
  localparam bit BRANCH_EN = 1'b1;
`else
  localparam bit BRANCH_EN = 1'b0;
`endif

  typedef struct {
    logic       isHalt;
    logic [3:0] pc;
    logic [3:0] op;
    logic [3:0] dst;
    logic       we;
  } rec_t;

  logic        clk;
  logic        reset;
  logic [15:0] mem [16];
  rec_t        expQ [$];
  bit          lastIsHalt;
  bit          sbEnable;
  bit          haltSeen;
  int          fetchAge;
  int          testsRun;
  int          failCount;

  fde_if #(.PC_W(PCW)) bus ();

  fde_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.instr_in = mem[bus.pc];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Walks the program one instruction at a time, recording what each commit must look like.
  task automatic modelProgram(input int maxInstr);
    int         p;
    logic [15:0] w;
    rec_t        r;
    bit          jmp;
    p = 0;
    lastIsHalt = 1'b0;
    for (int i = 0; i < maxInstr; i++) begin
      w = mem[p];
      r.pc  = p[3:0];
      r.op  = w[15:12];
      r.dst = w[11:8];
      if (w[15:12] == 4'hE) begin
        r.isHalt = 1'b1;
        r.we     = 1'b0;
        expQ.push_back(r);
        lastIsHalt = 1'b1;
        break;
      end
      jmp      = BRANCH_EN && (w[15:12] == 4'hF);
      r.isHalt = 1'b0;
      r.we     = (w[15:12] != 4'h0) && !jmp;
      expQ.push_back(r);
      p = jmp ? int'(w[3:0]) : (p + 1) % 16;
    end
  endtask

  task automatic applyStimulus(input bit holdStop);
    bus.stop = 1'b1;
    reset    = 1'b0;
    repeat (2) @(negedge clk);
    reset    = 1'b1;
    bus.stop = holdStop;
  endtask

  task automatic runProgram(input int maxInstr, input bit randomStop);
    expQ.delete();
    applyStimulus(1'b1);
    modelProgram(maxInstr);
    sbEnable = 1'b1;
    bus.stop = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (expQ.size() == 0) break;
      if (randomStop) bus.stop = ($urandom_range(0, 3) == 0);
    end
    checkOutput("sb_drain", expQ.size(), 0);
    if (lastIsHalt && expQ.size() == 0) begin
      for (int k = 0; k < 4; k++) begin
        bus.stop = k[0];
        @(negedge clk);
        checkOutput("halt_hold", bus.halted, 1'b1);
      end
    end
    sbEnable = 1'b0;
    reset    = 1'b0;
    @(negedge clk);
    checkOutput("rst_state", bus.state, 3'd0);
    checkOutput("rst_pc", bus.pc, 0);
    reset = 1'b1;
  endtask

  // Monitor: pops the next expected commit whenever the DUT writes back or halts.
  always @(negedge clk) begin
    rec_t r;
    if (!reset) begin
      haltSeen = 1'b0;
      fetchAge = 0;
    end else begin
      if (bus.ir_load) fetchAge = 0;
      else fetchAge = fetchAge + 1;
      if (sbEnable) begin
        checkOutput("strobe_onehot",
                    ($countones({bus.ir_load, bus.alu_en, bus.rf_we, bus.halted}) <= 1), 1'b1);
        if (bus.state == 3'd4 || (bus.halted && !haltSeen)) begin
          if (expQ.size() == 0) begin
            checkOutput("sb_unexpected", bus.state, 3'd7);
          end else begin
            r = expQ.pop_front();
            checkOutput("sb_kind", bus.halted, r.isHalt);
            checkOutput("sb_pc", bus.pc, r.pc);
            checkOutput("sb_opcode", bus.opcode, r.op);
            checkOutput("sb_dstadd", bus.dstadd, r.dst);
            checkOutput("sb_rf_we", bus.rf_we, r.we);
            checkOutput("sb_latency", fetchAge, 3);
          end
          if (bus.halted) haltSeen = 1'b1;
        end
      end
    end
  end

  int seq [12] = '{1, 2, 3, 4, 1, 2, 3, 4, 1, 2, 3, 5};

  initial begin
    testsRun  = 0;
    failCount = 0;
    sbEnable  = 1'b0;
    haltSeen  = 1'b0;
    fetchAge  = 0;
    for (int i = 0; i < 16; i++) mem[i] = 16'hE000;

    // Reset then hold stop: IDLE, pc 0, all strobes low.
    applyStimulus(1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checkOutput("idle_state", bus.state, 3'd0);
      checkOutput("idle_pc", bus.pc, 0);
      checkOutput("idle_strobes", {bus.ir_load, bus.alu_en, bus.rf_we, bus.halted}, 4'b0);
      checkOutput("idle_ir", {bus.opcode, bus.dstadd, bus.srcadd_1, bus.srcadd_2}, 16'h0000);
    end

    // Two back-to-back instructions followed by HALT.
    mem[0] = 16'h1123;
    mem[1] = 16'h2456;
    mem[2] = 16'hE000;
    bus.stop = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checkOutput("run_state", bus.state, seq[k]);
      if (k == 3) begin
        checkOutput("run_we0", bus.rf_we, 1'b1);
        checkOutput("run_dst0", bus.dstadd, 4'd1);
        checkOutput("run_src0", {bus.srcadd_1, bus.srcadd_2}, 8'h23);
      end
      if (k == 7) begin
        checkOutput("run_we1", bus.rf_we, 1'b1);
        checkOutput("run_dst1", bus.dstadd, 4'd4);
      end
      if (k == 8) checkOutput("run_pc2", bus.pc, 2);
      if (k == 10) checkOutput("halt_no_we", bus.rf_we, 1'b0);
    end
    checkOutput("halted", bus.halted, 1'b1);
    for (int k = 0; k < 4; k++) begin
      bus.stop = ~bus.stop;
      @(negedge clk);
      checkOutput("halt_state", bus.state, 3'd5);
      checkOutput("halt_pc", bus.pc, 2);
    end
    reset = 1'b0;
    @(negedge clk);
    checkOutput("halt_rst_state", bus.state, 3'd0);
    checkOutput("halt_rst_pc", bus.pc, 0);
    reset = 1'b1;

    // Stop raised in EXECUTE lets the instruction finish, then parks in IDLE.
    applyStimulus(1'b1);
    @(negedge clk);
    bus.stop = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("mid_exec", bus.state, 3'd3);
    bus.stop = 1'b1;
    @(negedge clk);
    checkOutput("mid_wb", bus.state, 3'd4);
    checkOutput("mid_wb_we", bus.rf_we, 1'b1);
    @(negedge clk);
    checkOutput("mid_idle", bus.state, 3'd0);
    checkOutput("mid_pc", bus.pc, 1);
    @(negedge clk);
    checkOutput("mid_idle_hold", bus.state, 3'd0);
    bus.stop = 1'b0;
    @(negedge clk);
    checkOutput("mid_refetch", bus.state, 3'd1);
    checkOutput("mid_refetch_pc", bus.pc, 1);

    // All-NOP memory: pc wraps from 15 to 0, no register writes.
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
    runProgram(18, 1'b0);

    // Opcode F at address 3: jump or ordinary ALU op depending on the build.
    for (int i = 0; i < 16; i++) mem[i] = 16'hE000;
    mem[0] = 16'h1000;
    mem[1] = 16'h2000;
    mem[2] = 16'h3000;
    mem[3] = 16'hF009;
    runProgram(20, 1'b0);

    // Random programs with random stop activity.
    for (int t = 0; t < 8; t++) begin
      for (int i = 0; i < 16; i++) mem[i] = 16'($urandom);
      runProgram(30, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
